// File: rtl/fpu_op_master.sv
// Initiator for the FPU stb/ack operand protocol: accepts A/B from upstream, feeds the FPU, returns Z.
// Optional watchdog on the FPU wait states is enabled by defining FPU_MASTER_TIMEOUT_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | ready for a new request, operands latched on accept
// SEND_A   | strobing operand A until fpu_a_ack (first cycle pulses start)
// SEND_B   | strobing operand B until fpu_b_ack
// WAIT_Z   | acking the result channel until fpu_z_stb
// HOLD_RES | presenting res_z upstream until res_ready

module fpu_op_master #(
  parameter int DATA_W         = 32,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_z,
  output logic              fpu_start,
  output logic [DATA_W-1:0] fpu_a,
  output logic              fpu_a_stb,
  input  logic              fpu_a_ack,
  output logic [DATA_W-1:0] fpu_b,
  output logic              fpu_b_stb,
  input  logic              fpu_b_ack,
  input  logic [DATA_W-1:0] fpu_z,
  input  logic              fpu_z_stb,
  output logic              fpu_z_ack,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count,
  output logic              timeout_err
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND_A   = 3'd1,
    SEND_B   = 3'd2,
    WAIT_Z   = 3'd3,
    HOLD_RES = 3'd4
  } state_t;

  localparam logic [DATA_W-1:0] QNAN = DATA_W'(32'h7FC0_0000);

  state_t state;
  state_t state_next;
  logic   start_q;
  logic   accept;
  logic   fpu_hs;
  logic   res_hs;
  logic   tmo_hit;
  logic   tmo_fire;

  assign accept   = (state == IDLE) && req_valid;
  assign res_hs   = (state == HOLD_RES) && res_ready;
  assign tmo_fire = tmo_hit && !fpu_hs;

  // Handshake of whichever FPU channel the current state owns; others are ignored.
  always_comb begin
    fpu_hs = 1'b0;
    case (state)
      SEND_A:  fpu_hs = fpu_a_ack;
      SEND_B:  fpu_hs = fpu_b_ack;
      WAIT_Z:  fpu_hs = fpu_z_stb;
      default: fpu_hs = 1'b0;
    endcase
  end

`ifdef FPU_MASTER_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_err_q;
  logic             waiting;

  assign waiting = (state == SEND_A) || (state == SEND_B) || (state == WAIT_Z);
  assign tmo_hit = waiting && (tmo_cnt == '0);

  // Down-counter reloads on every state change so each wait state gets a full budget.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt   <= TMO_W'(TIMEOUT_CYCLES - 1);
      tmo_err_q <= 1'b0;
    end else begin
      if (state_next != state || !waiting) begin
        tmo_cnt <= TMO_W'(TIMEOUT_CYCLES - 1);
      end else if (tmo_cnt != '0) begin
        tmo_cnt <= tmo_cnt - 1'b1;
      end
      if (tmo_fire) begin
        tmo_err_q <= 1'b1;
      end
    end
  end

  assign timeout_err = tmo_err_q;
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid) state_next = SEND_A;
      end
      SEND_A: begin
        if (fpu_a_ack)    state_next = SEND_B;
        else if (tmo_hit) state_next = HOLD_RES;
      end
      SEND_B: begin
        if (fpu_b_ack)    state_next = WAIT_Z;
        else if (tmo_hit) state_next = HOLD_RES;
      end
      WAIT_Z: begin
        if (fpu_z_stb)    state_next = HOLD_RES;
        else if (tmo_hit) state_next = HOLD_RES;
      end
      HOLD_RES: begin
        if (res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    fpu_a_stb = 1'b0;
    fpu_b_stb = 1'b0;
    fpu_z_ack = 1'b0;
    res_valid = 1'b0;
    busy      = (state != IDLE);
    fpu_start = start_q;
    case (state)
      IDLE:     req_ready = 1'b1;
      SEND_A:   fpu_a_stb = 1'b1;
      SEND_B:   fpu_b_stb = 1'b1;
      WAIT_Z:   fpu_z_ack = 1'b1;
      HOLD_RES: res_valid = 1'b1;
      default:  req_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_q  <= 1'b0;
      fpu_a    <= '0;
      fpu_b    <= '0;
      res_z    <= '0;
      op_count <= '0;
    end else begin
      start_q <= accept;
      if (accept) begin
        fpu_a <= req_a;
        fpu_b <= req_b;
      end
      if (state == WAIT_Z && fpu_z_stb) begin
        res_z <= fpu_z;
      end else if (tmo_fire) begin
        res_z <= QNAN;
      end
      if (res_hs) begin
        op_count <= op_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fpu_op_master.sv
// Directed plus randomized bench for fpu_op_master; the FPU stand-in returns a+b.
// Build with FPU_MASTER_TIMEOUT_EN defined to exercise the watchdog path.

module tb_fpu_op_master;

  localparam int DW = 32;
  localparam int CW = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [DW-1:0] req_a = '0;
  logic [DW-1:0] req_b = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [DW-1:0] res_z;
  logic          fpu_start;
  logic [DW-1:0] fpu_a;
  logic          fpu_a_stb;
  logic          fpu_a_ack = 1'b0;
  logic [DW-1:0] fpu_b;
  logic          fpu_b_stb;
  logic          fpu_b_ack = 1'b0;
  logic [DW-1:0] fpu_z = '0;
  logic          fpu_z_stb = 1'b0;
  logic          fpu_z_ack;
  logic          busy;
  logic [CW-1:0] op_count;
  logic          timeout_err;

  int checks    = 0;
  int errors    = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  fpu_op_master #(.DATA_W(DW), .CNT_W(CW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_z(res_z),
    .fpu_start(fpu_start),
    .fpu_a(fpu_a), .fpu_a_stb(fpu_a_stb), .fpu_a_ack(fpu_a_ack),
    .fpu_b(fpu_b), .fpu_b_stb(fpu_b_stb), .fpu_b_ack(fpu_b_ack),
    .fpu_z(fpu_z), .fpu_z_stb(fpu_z_stb), .fpu_z_ack(fpu_z_ack),
    .busy(busy), .op_count(op_count), .timeout_err(timeout_err)
  );

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_fpu_inputs();
    fpu_a_ack = 1'b0;
    fpu_b_ack = 1'b0;
    fpu_z_stb = 1'b0;
    fpu_z     = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    req_valid = 1'b0;
    res_ready = 1'b0;
    clear_fpu_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_count = 0;
    @(negedge clk);
  endtask

  // One complete operation with per-phase delays; spur injects acks/strobes that belong to other phases.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input int da, input int db, input int dz, input int dr, input bit spur);
    logic [31:0] z;
    z = a + b;
    chkb("idle_req_ready", req_ready, 1'b1);
    req_valid = 1'b1;
    req_a = a;
    req_b = b;
    @(negedge clk);
    req_valid = 1'($urandom_range(0, 1));
    req_a = $urandom;
    req_b = $urandom;
    for (int i = 0; i <= da; i++) begin
      chkb("a_stb", fpu_a_stb, 1'b1);
      chkw("fpu_a", fpu_a, a);
      chkb("a_start", fpu_start, (i == 0));
      chkb("a_z_ack", fpu_z_ack, 1'b0);
      chkb("a_b_stb", fpu_b_stb, 1'b0);
      fpu_a_ack = (i == da);
      fpu_b_ack = spur;
      fpu_z_stb = spur;
      fpu_z = $urandom;
      @(negedge clk);
    end
    clear_fpu_inputs();
    for (int i = 0; i <= db; i++) begin
      chkb("b_stb", fpu_b_stb, 1'b1);
      chkb("b_a_stb", fpu_a_stb, 1'b0);
      chkw("fpu_b", fpu_b, b);
      chkb("b_start", fpu_start, 1'b0);
      fpu_b_ack = (i == db);
      fpu_a_ack = spur;
      fpu_z_stb = spur;
      @(negedge clk);
    end
    clear_fpu_inputs();
    for (int i = 0; i <= dz; i++) begin
      chkb("z_ack", fpu_z_ack, 1'b1);
      chkb("z_res_valid", res_valid, 1'b0);
      fpu_z_stb = (i == dz);
      fpu_z = (i == dz) ? z : $urandom;
      fpu_a_ack = spur;
      fpu_b_ack = spur;
      @(negedge clk);
    end
    clear_fpu_inputs();
    for (int i = 0; i <= dr; i++) begin
      chkb("hold_res_valid", res_valid, 1'b1);
      chkw("hold_res_z", res_z, z);
      chkb("hold_req_ready", req_ready, 1'b0);
      chkb("hold_z_ack", fpu_z_ack, 1'b0);
      req_valid = 1'b1;
      res_ready = (i == dr);
      fpu_z_stb = spur;
      fpu_z = $urandom;
      @(negedge clk);
    end
    res_ready = 1'b0;
    req_valid = 1'b0;
    clear_fpu_inputs();
    exp_count = (exp_count + 1) % (1 << CW);
    chkw("op_count", 32'(op_count), 32'(exp_count));
    chkb("post_busy", busy, 1'b0);
    chkb("post_res_valid", res_valid, 1'b0);
  endtask

  initial begin
    int n;

    // Reset, then idle outputs
    do_reset();
    chkb("rst_req_ready", req_ready, 1'b1);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_a_stb", fpu_a_stb, 1'b0);
    chkb("rst_b_stb", fpu_b_stb, 1'b0);
    chkb("rst_z_ack", fpu_z_ack, 1'b0);
    chkb("rst_start", fpu_start, 1'b0);
    chkb("rst_res_valid", res_valid, 1'b0);
    chkb("rst_timeout", timeout_err, 1'b0);
    chkw("rst_op_count", 32'(op_count), 32'd0);
    chkw("rst_res_z", res_z, 32'd0);
    chkw("rst_fpu_a", fpu_a, 32'd0);

    // Nominal add with FPU inputs held high: minimum latency path
    req_valid = 1'b1;
    req_a = 32'h417C0000;
    req_b = 32'h40E80000;
    fpu_a_ack = 1'b1;
    fpu_b_ack = 1'b1;
    fpu_z_stb = 1'b1;
    fpu_z = 32'h41B80000;
    @(negedge clk);
    req_valid = 1'b0;
    req_a = '0;
    req_b = '0;
    chkb("nom_start", fpu_start, 1'b1);
    chkb("nom_a_stb", fpu_a_stb, 1'b1);
    chkb("nom_b_stb0", fpu_b_stb, 1'b0);
    chkw("nom_fpu_a", fpu_a, 32'h417C0000);
    @(negedge clk);
    chkb("nom_start_once", fpu_start, 1'b0);
    chkb("nom_b_stb", fpu_b_stb, 1'b1);
    chkw("nom_fpu_b", fpu_b, 32'h40E80000);
    @(negedge clk);
    chkb("nom_z_ack", fpu_z_ack, 1'b1);
    chkb("nom_res_valid_early", res_valid, 1'b0);
    @(negedge clk);
    clear_fpu_inputs();
    chkb("nom_res_valid_3cyc", res_valid, 1'b1);
    chkw("nom_res_z", res_z, 32'h41B80000);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    exp_count = 1;
    chkw("nom_op_count", 32'(op_count), 32'd1);
    chkb("nom_idle", busy, 1'b0);

    // Backpressure on A and on the result; spurious inputs during SEND_A
    run_op(32'h3F800000, 32'h40000000, 5, 0, 0, 4, 1'b0);
    run_op(32'h12345678, 32'h0F0F0F0F, 3, 2, 1, 0, 1'b1);

    // Reset in the middle of WAIT_Z
    @(negedge clk);
    req_valid = 1'b1;
    req_a = $urandom;
    req_b = $urandom;
    fpu_a_ack = 1'b1;
    fpu_b_ack = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    clear_fpu_inputs();
    chkb("mid_z_ack_before", fpu_z_ack, 1'b1);
    rst = 1'b0;
    #1;
    chkb("mid_busy", busy, 1'b0);
    chkb("mid_z_ack", fpu_z_ack, 1'b0);
    chkb("mid_res_valid", res_valid, 1'b0);
    chkw("mid_op_count", 32'(op_count), 32'd0);
    chkb("mid_req_ready", req_ready, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    exp_count = 0;
    @(negedge clk);

    // Randomized operations; enough of them to wrap the 4-bit counter
    for (int k = 0; k < 20; k++) begin
      run_op($urandom, $urandom, $urandom_range(0, 5), $urandom_range(0, 5),
             $urandom_range(0, 5), $urandom_range(0, 5), 1'($urandom_range(0, 1)));
    end

    // Operand B never acknowledged
    req_valid = 1'b1;
    req_a = 32'h3F800000;
    req_b = 32'h3F800000;
    fpu_a_ack = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    fpu_a_ack = 1'b0;
    n = 0;
    while (fpu_b_stb && n < 100) begin
      n++;
      @(negedge clk);
    end
`ifdef FPU_MASTER_TIMEOUT_EN
    chkw("tmo_send_b_cycles", 32'(n), 32'(TO));
    chkb("tmo_res_valid", res_valid, 1'b1);
    chkw("tmo_res_z", res_z, 32'h7FC00000);
    chkb("tmo_err", timeout_err, 1'b1);
    chkb("tmo_b_stb", fpu_b_stb, 1'b0);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    exp_count = (exp_count + 1) % (1 << CW);
    chkw("tmo_op_count", 32'(op_count), 32'(exp_count));
    chkb("tmo_err_sticky", timeout_err, 1'b1);
    run_op(32'h00000005, 32'h00000007, 0, 0, 0, 0, 1'b0);
    chkb("tmo_err_sticky2", timeout_err, 1'b1);
`else
    chkw("notmo_cycles", 32'(n), 32'd100);
    chkb("notmo_b_stb", fpu_b_stb, 1'b1);
    chkb("notmo_busy", busy, 1'b1);
    chkb("notmo_err", timeout_err, 1'b0);
    do_reset();
    chkb("notmo_recover", req_ready, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit exceeded");
  end

endmodule
